// File: rtl/ptcalc_mul_pipe_rsat.sv
// Pipelined signed multiplier for the pT datapath: full-width product, round-half-up
// right shift, saturation to dout_WIDTH, valid tag, clock-enable stall, sticky overflow.
module ptcalc_mul_pipe_rsat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 21,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 18,
  parameter int SHIFT      = 9
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_sat,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int W      = din0_WIDTH + din1_WIDTH;
  localparam int RW     = (W + 1 > dout_WIDTH + 1) ? W + 1 : dout_WIDTH + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

  logic signed [din0_WIDTH-1:0] mul_a;
  logic signed [din1_WIDTH-1:0] mul_b;
  logic                         mul_vld;
  logic signed [W-1:0]          mul_p;
  logic signed [W-1:0]          fin_p;
  logic                         fin_vld;

  // Stage 1 is the operand register unless the whole pipe is a single output register.
  if (NUM_STAGE == 1) begin : g_comb_in
    assign mul_a   = din0;
    assign mul_b   = din1;
    assign mul_vld = din_vld;
  end else begin : g_op_reg
    logic [din0_WIDTH-1:0] a_d, a_q;
    logic [din1_WIDTH-1:0] b_d, b_q;
    logic                  vld_d, vld_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      vld_d = vld_q;
      if (ce) begin
        a_d   = din0;
        b_d   = din1;
        vld_d = din_vld;
      end
    end

    // NOTE: sequential state uses non-blocking assignments only; data registers are
    // reset too so dout is never X after reset, even while invalid.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        a_q   <= a_d;
        b_q   <= b_d;
        vld_q <= vld_d;
      end
    end

    assign mul_a   = a_q;
    assign mul_b   = b_q;
    assign mul_vld = vld_q;
  end

  // Full-width signed product; both operands signed so sign extension happens to W.
  assign mul_p = mul_a * mul_b;

  if (NUM_STAGE <= 2) begin : g_no_pdelay
    assign fin_p   = mul_p;
    assign fin_vld = mul_vld;
  end else begin : g_pdelay
    localparam int D = NUM_STAGE - 2;
    logic [W-1:0] p_d [D];
    logic [W-1:0] p_q [D];
    logic [D-1:0] pv_d, pv_q;

    always_comb begin
      p_d  = p_q;
      pv_d = pv_q;
      if (ce) begin
        p_d[0]  = mul_p;
        pv_d[0] = mul_vld;
        for (int i = 1; i < D; i++) begin
          p_d[i]  = p_q[i-1];
          pv_d[i] = pv_q[i-1];
        end
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < D; i++) p_q[i] <= '0;
        pv_q <= '0;
      end else begin
        p_q  <= p_d;
        pv_q <= pv_d;
      end
    end

    assign fin_p   = p_q[D-1];
    assign fin_vld = pv_q[D-1];
  end

  // Round half up in a widened word so the bias add can never wrap, then clamp.
  logic signed [RW-1:0]  p_ext, r_wide;
  logic [dout_WIDTH-1:0] sat_val;
  logic                  sat_hit;

  always_comb begin
    p_ext   = {{(RW-W){fin_p[W-1]}}, fin_p};
    r_wide  = (p_ext + RND) >>> SHIFT;
    sat_val = r_wide[dout_WIDTH-1:0];
    sat_hit = 1'b0;
    if (r_wide > SAT_MAX) begin
      sat_val = {1'b0, {(dout_WIDTH-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (r_wide < SAT_MIN) begin
      sat_val = {1'b1, {(dout_WIDTH-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  logic [dout_WIDTH-1:0] dout_d, dout_q;
  logic                  dout_vld_d, dout_vld_q;
  logic                  dout_sat_d, dout_sat_q;
  logic                  ovf_d, ovf_q;

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    dout_sat_d = dout_sat_q;
    if (ce) begin
      dout_d     = sat_val;
      dout_vld_d = fin_vld;
      dout_sat_d = fin_vld & sat_hit;
    end
    // Clear ignores ce; a saturated load on the same edge takes priority.
    ovf_d = (ce & fin_vld & sat_hit) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_sat_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_sat_q <= dout_sat_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign dout_sat   = dout_sat_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ptcalc_mul_pipe_rsat.sv
// Directed bench for ptcalc_mul_pipe_rsat: main instance at NUM_STAGE=3 plus
// NUM_STAGE 1, 2 and 5 instances sharing inputs for the reset/scoreboard phase.
module tb_ptcalc_mul_pipe_rsat;

  localparam int NDUT = 4;
  localparam int LAT [NDUT] = '{3, 1, 2, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic        din_vld = 1'b0;
  logic [20:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic        ovf_clr = 1'b0;

  logic        vld_o [NDUT];
  logic [17:0] dout_o [NDUT];
  logic        sat_o [NDUT];
  logic        ovf_o [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptcalc_mul_pipe_rsat #(.ID(1), .NUM_STAGE(3)) u_dut3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_o[0]), .dout(dout_o[0]), .dout_sat(sat_o[0]), .ovf_sticky(ovf_o[0]),
    .ovf_clr(ovf_clr));
  ptcalc_mul_pipe_rsat #(.ID(2), .NUM_STAGE(1)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_o[1]), .dout(dout_o[1]), .dout_sat(sat_o[1]), .ovf_sticky(ovf_o[1]),
    .ovf_clr(ovf_clr));
  ptcalc_mul_pipe_rsat #(.ID(3), .NUM_STAGE(2)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_o[2]), .dout(dout_o[2]), .dout_sat(sat_o[2]), .ovf_sticky(ovf_o[2]),
    .ovf_clr(ovf_clr));
  ptcalc_mul_pipe_rsat #(.ID(4), .NUM_STAGE(5)) u_dut5 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_o[3]), .dout(dout_o[3]), .dout_sat(sat_o[3]), .ovf_sticky(ovf_o[3]),
    .ovf_clr(ovf_clr));

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Outputs sampled 1 time unit after the rising edge; inputs changed at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for 21x12 -> 18 with SHIFT=9: floor((P + 256) / 512), then clamp.
  function automatic longint model(input longint a, input longint b, output bit sat);
    longint p, r;
    p = a * b;
    r = (p + 256) >>> 9;
    sat = 1'b0;
    if (r > 131071) begin
      sat = 1'b1;
      r = 131071;
    end else if (r < -131072) begin
      sat = 1'b1;
      r = -131072;
    end
    return r;
  endfunction

  // One isolated sample through the NUM_STAGE=3 instance, checked at exact latency.
  task automatic send(input string tag, input int a, input int b, input int exp_dout,
                      input bit exp_sat, input bit clr_at_out);
    ce = 1'b1;
    din0 = 21'(a);
    din1 = 12'(b);
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    check({tag, "_lat1"}, vld_o[0], 0);
    step();
    check({tag, "_lat2"}, vld_o[0], 0);
    if (clr_at_out) ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check({tag, "_vld"}, vld_o[0], 1);
    check({tag, "_dout"}, $signed(dout_o[0]), exp_dout);
    check({tag, "_sat"}, sat_o[0], exp_sat);
  endtask

  // Stall table: b=512 so dout equals a; expected outputs worked out by ce-edge count.
  localparam int NT = 9;
  bit ce_t    [NT] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  bit vld_t   [NT] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
  int a_t     [NT] = '{10, 99, 0, 30, 0, 0, 0, 0, 0};
  bit ev_t    [NT] = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
  int ed_t    [NT] = '{0, 0, 0, 10, 10, 0, 30, 0, 0};

  localparam int NR = 24;
  logic [20:0] ha [NR+1];
  logic [11:0] hb [NR+1];
  bit          hv [NR+1];

  initial begin
    bit    s;
    longint e;
    int    j;

    #2 rst_n = 1'b0;
    #1;
    check("rst_vld", vld_o[0], 0);
    check("rst_dout", $signed(dout_o[0]), 0);
    check("rst_sat", sat_o[0], 0);
    check("rst_ovf", ovf_o[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    ce = 1'b1;
    step();
    step();

    send("p513", 3, 171, 1, 0, 0);
    send("p255", 3, 85, 0, 0, 0);
    send("n256", -1, 256, 0, 0, 0);
    send("n257", -1, 257, -1, 0, 0);
    check("ovf_pre", ovf_o[0], 0);
    send("satmax", -1048576, -2048, 131071, 1, 0);
    check("ovf_set", ovf_o[0], 1);
    send("satmin", -1048576, 2047, -131072, 1, 1);
    check("ovf_set_wins", ovf_o[0], 1);

    // Clear with ce=0: output stage frozen, sticky still clears.
    ce = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr_noce", ovf_o[0], 0);
    check("hold_vld", vld_o[0], 1);
    check("hold_sat", sat_o[0], 1);
    check("hold_dout", $signed(dout_o[0]), -131072);
    ce = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("bubble_vld", vld_o[0], 0);
    check("bubble_sat", sat_o[0], 0);
    check("ovf_stays0", ovf_o[0], 0);

    din1 = 12'd512;
    for (int k = 0; k < NT; k++) begin
      ce = ce_t[k];
      din_vld = vld_t[k];
      din0 = 21'(a_t[k]);
      step();
      check($sformatf("stall_vld_%0d", k), vld_o[0], ev_t[k]);
      if (ev_t[k]) check($sformatf("stall_dout_%0d", k), $signed(dout_o[0]), ed_t[k]);
    end

    // Reset mid-stream with three samples in flight.
    ce = 1'b1;
    din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din0 = 21'(1000 * (i + 1));
      din1 = 12'd700;
      step();
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("midrst_vld_%0d", d), vld_o[d], 0);
      check($sformatf("midrst_dout_%0d", d), $signed(dout_o[d]), 0);
    end
    #4 rst_n = 1'b1;

    for (int k = 1; k <= NR; k++) begin
      case (k % 6)
        0: begin ha[k] = 21'h100000; hb[k] = 12'h800; end
        3: begin ha[k] = 21'h100000; hb[k] = 12'h7ff; end
        default: begin ha[k] = 21'($urandom); hb[k] = 12'($urandom); end
      endcase
      hv[k] = ($urandom_range(0, 9) < 7);
      din0 = ha[k];
      din1 = hb[k];
      din_vld = hv[k];
      step();
      for (int d = 0; d < NDUT; d++) begin
        j = k - LAT[d] + 1;
        if (j < 1) begin
          check($sformatf("stale_vld_n%0d_k%0d", LAT[d], k), vld_o[d], 0);
        end else begin
          check($sformatf("rnd_vld_n%0d_k%0d", LAT[d], k), vld_o[d], hv[j]);
          if (hv[j]) begin
            e = model(longint'($signed(ha[j])), longint'($signed(hb[j])), s);
            check($sformatf("rnd_dout_n%0d_k%0d", LAT[d], k), $signed(dout_o[d]), e);
            check($sformatf("rnd_sat_n%0d_k%0d", LAT[d], k), sat_o[d], s);
          end else begin
            check($sformatf("rnd_sat0_n%0d_k%0d", LAT[d], k), sat_o[d], 0);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
